// File: rtl/aq_jpeg_pkg.sv
// rtl/aq_jpeg_pkg.sv - shared FSM encoding, byte constants and accumulator sizing for the JPEG bit packer
package aq_jpeg_pkg;

    // Bit accumulator: left-aligned, oldest bit at the MSB
    localparam int ACC_W  = 64;
    localparam int FILL_W = 7;

    // Entropy-coded segment byte values
    localparam logic [7:0] BYTE_FF = 8'hFF;
    localparam logic [7:0] BYTE_00 = 8'h00;

    // Flush sequencing states
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_PAD   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Mask of len bits starting pos bits below the accumulator MSB.
    // Shifts of ACC_W or more yield zero, so pos+len may reach ACC_W.
    function automatic logic [ACC_W-1:0] span_mask(input logic [FILL_W:0] pos,
                                                   input logic [FILL_W:0] len);
        logic [ACC_W-1:0] all_ones;
        all_ones = '1;
        return (all_ones >> pos) & ~(all_ones >> (pos + len));
    endfunction

endpackage

// File: rtl/aq_jpeg_bitpack_word.sv
// rtl/aq_jpeg_bitpack_word.sv - byte-to-word assembler with one-word skid in front of the output register
module aq_jpeg_bitpack_word
    import aq_jpeg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic        flush_partial,
    output logic [31:0] word_data,
    output logic [2:0]  word_bytes,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        empty
);

    logic [31:0] asm_q, asm_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] out_data_q, out_data_d;
    logic [2:0]  out_bytes_q, out_bytes_d;
    logic        out_valid_q, out_valid_d;

    logic        out_free;
    logic        asm_full;
    logic        byte_take;
    logic [31:0] base_asm;
    logic [2:0]  base_cnt;
    logic [31:0] merged;

    // Assembler doubles as the skid: it keeps filling while the output word waits
    always_comb begin
        out_free    = !out_valid_q || word_ready;
        asm_full    = (cnt_q == 3'd4);
        byte_ready  = !asm_full || out_free;
        byte_take   = byte_valid && byte_ready;

        asm_d       = asm_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_bytes_d = out_bytes_q;
        out_valid_d = out_valid_q;
        base_asm    = asm_q;
        base_cnt    = cnt_q;
        merged      = asm_q;

        if (out_valid_q && word_ready) begin
            out_valid_d = 1'b0;
        end

        // A word that completed while the output was busy moves up first
        if (asm_full && out_free) begin
            out_data_d  = asm_q;
            out_bytes_d = 3'd4;
            out_valid_d = 1'b1;
            base_asm    = 32'd0;
            base_cnt    = 3'd0;
        end

        if (byte_take) begin
            merged = base_asm | ({byte_data, 24'd0} >> {base_cnt, 3'b000});
            if (base_cnt == 3'd3 && out_free && !asm_full) begin
                // Fourth byte goes straight to the output to save a cycle
                out_data_d  = merged;
                out_bytes_d = 3'd4;
                out_valid_d = 1'b1;
                asm_d       = 32'd0;
                cnt_d       = 3'd0;
            end else begin
                asm_d = merged;
                cnt_d = base_cnt + 3'd1;
            end
        end else if (flush_partial && cnt_q != 3'd0 && !asm_full && out_free) begin
            out_data_d  = asm_q;
            out_bytes_d = cnt_q;
            out_valid_d = 1'b1;
            asm_d       = 32'd0;
            cnt_d       = 3'd0;
        end else begin
            asm_d = base_asm;
            cnt_d = base_cnt;
        end
    end

    // Assembler and output word registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q       <= 32'd0;
            cnt_q       <= 3'd0;
            out_data_q  <= 32'd0;
            out_bytes_q <= 3'd0;
            out_valid_q <= 1'b0;
        end else begin
            asm_q       <= asm_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_bytes_q <= out_bytes_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign word_data  = out_data_q;
    assign word_bytes = out_bytes_q;
    assign word_valid = out_valid_q;
    assign empty      = (cnt_q == 3'd0) && !out_valid_q;

endmodule

// File: rtl/aq_jpeg_bitpack.sv
// rtl/aq_jpeg_bitpack.sv - JPEG entropy bit packer; 0xFF/0x00 stuffing under macro AQ_JPEG_BITPACK_STUFF_EN
module aq_jpeg_bitpack
    import aq_jpeg_pkg::*;
#(
    parameter int CODE_W_MAX = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] CodeIn,
    input  logic [5:0]  CodeWidth,
    input  logic        CodeRaw,
    input  logic        CodeEnable,
    output logic        CodeReady,
    input  logic        Flush,
    output logic        FlushDone,
    output logic [31:0] DataOut,
    output logic [2:0]  DataOutBytes,
    output logic        DataOutEnable,
    input  logic        DataOutReady,
    output logic        Idle
);

`ifdef AQ_JPEG_BITPACK_STUFF_EN
    localparam bit STUFF_EN = 1'b1;
`else
    localparam bit STUFF_EN = 1'b0;
`endif

    localparam logic [6:0] CODE_W_LIM = 7'(CODE_W_MAX);

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  raw_q, raw_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              stuff_q, stuff_d;
    logic [1:0]        state_q, state_d;

    logic              code_fire;
    logic [6:0]        code_w;
    logic [31:0]       code_mask;
    logic [31:0]       code_bits;
    logic [ACC_W-1:0]  code_left;
    logic [ACC_W-1:0]  code_place;
    logic [3:0]        pad_n;
    logic [ACC_W-1:0]  acc_s, raw_s;
    logic [FILL_W-1:0] fill_s, fill_p;

    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              byte_take;
    logic              flush_partial;
    logic              word_empty;

    assign code_fire = CodeEnable && CodeReady;

    // Width clamp and right-aligned code masking
    always_comb begin
        code_w = ({1'b0, CodeWidth} > CODE_W_LIM) ? CODE_W_LIM : {1'b0, CodeWidth};
        if (code_w >= 7'd32) begin
            code_mask = '1;
        end else begin
            code_mask = (32'd1 << code_w) - 32'd1;
        end
        code_bits = CodeIn & code_mask;
    end

    // Byte extraction, stuffing, raw alignment padding and code append
    always_comb begin
        // A pending stuffed zero takes the byte slot ahead of accumulator bits
        byte_valid = 1'b0;
        byte_data  = BYTE_00;
        if (stuff_q) begin
            byte_valid = 1'b1;
            byte_data  = BYTE_00;
        end else if (fill_q >= 7'd8) begin
            byte_valid = 1'b1;
            byte_data  = acc_q[ACC_W-1 -: 8];
        end
        byte_take = byte_valid && byte_ready;

        acc_s   = acc_q;
        raw_s   = raw_q;
        fill_s  = fill_q;
        stuff_d = stuff_q;
        if (byte_take) begin
            if (stuff_q) begin
                stuff_d = 1'b0;
            end else begin
                acc_s  = acc_q << 8;
                raw_s  = raw_q << 8;
                fill_s = fill_q - 7'd8;
                // A byte counts as raw when its first bit came from a raw code
                if (STUFF_EN && acc_q[ACC_W-1 -: 8] == BYTE_FF && !raw_q[ACC_W-1]) begin
                    stuff_d = 1'b1;
                end
            end
        end

        // Ones fill to the byte boundary ahead of a raw code or at end of stream
        pad_n = 4'd0;
        if (fill_s[2:0] != 3'd0) begin
            if ((code_fire && CodeRaw && code_w != 7'd0) || state_q == ST_PAD) begin
                pad_n = 4'd8 - {1'b0, fill_s[2:0]};
            end
        end
        fill_p = fill_s + {3'b000, pad_n};
        acc_d  = acc_s | span_mask({1'b0, fill_s}, {4'b0000, pad_n});
        raw_d  = raw_s;
        fill_d = fill_p;

        code_left  = {code_bits, 32'd0} << (7'd32 - code_w);
        code_place = code_left >> fill_p;
        if (code_fire) begin
            acc_d  = acc_d | code_place;
            fill_d = fill_p + code_w;
            if (CodeRaw) begin
                raw_d = raw_s | span_mask({1'b0, fill_p}, {1'b0, code_w});
            end
        end
    end

    // Flush sequencing; an empty packer skips DRAIN so FlushDone follows quickly
    always_comb begin
        state_d       = state_q;
        flush_partial = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (Flush) begin
                    state_d = ST_PAD;
                end
            end
            ST_PAD: begin
                if (fill_q == 7'd0 && !stuff_q && word_empty) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fill_q == 7'd0 && !stuff_q) begin
                    flush_partial = 1'b1;
                    if (word_empty) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Accumulator, fill count, stuffing flag and state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q   <= '0;
            raw_q   <= '0;
            fill_q  <= '0;
            stuff_q <= 1'b0;
            state_q <= ST_RUN;
        end else begin
            acc_q   <= acc_d;
            raw_q   <= raw_d;
            fill_q  <= fill_d;
            stuff_q <= stuff_d;
            state_q <= state_d;
        end
    end

    aq_jpeg_bitpack_word u_word (
        .clk           (clk),
        .rst_n         (rst),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .byte_ready    (byte_ready),
        .flush_partial (flush_partial),
        .word_data     (DataOut),
        .word_bytes    (DataOutBytes),
        .word_valid    (DataOutEnable),
        .word_ready    (DataOutReady),
        .empty         (word_empty)
    );

    assign CodeReady = (state_q == ST_RUN) && (fill_q <= 7'd32);
    assign FlushDone = (state_q == ST_DONE);
    assign Idle      = (state_q == ST_RUN) && (fill_q == 7'd0) && !stuff_q && word_empty;

endmodule

// File: tb/tb_aq_jpeg_bitpack.sv
// tb/tb_aq_jpeg_bitpack.sv - scoreboard bench for aq_jpeg_bitpack with a bit-queue reference model
module tb_aq_jpeg_bitpack;

`ifdef AQ_JPEG_BITPACK_STUFF_EN
    localparam bit STUFF = 1'b1;
`else
    localparam bit STUFF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] CodeIn = '0;
    logic [5:0]  CodeWidth = '0;
    logic        CodeRaw = 1'b0;
    logic        CodeEnable = 1'b0;
    logic        CodeReady;
    logic        Flush = 1'b0;
    logic        FlushDone;
    logic [31:0] DataOut;
    logic [2:0]  DataOutBytes;
    logic        DataOutEnable;
    logic        DataOutReady = 1'b1;
    logic        Idle;

    always #5 clk = ~clk;

    aq_jpeg_bitpack #(.CODE_W_MAX(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .CodeIn        (CodeIn),
        .CodeWidth     (CodeWidth),
        .CodeRaw       (CodeRaw),
        .CodeEnable    (CodeEnable),
        .CodeReady     (CodeReady),
        .Flush         (Flush),
        .FlushDone     (FlushDone),
        .DataOut       (DataOut),
        .DataOutBytes  (DataOutBytes),
        .DataOutEnable (DataOutEnable),
        .DataOutReady  (DataOutReady),
        .Idle          (Idle)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_data[$];
    logic [2:0]  exp_bytes[$];
    bit          pend[$];
    bit          pend_raw;
    logic [7:0]  ebytes[$];
    logic [31:0] last_data = '0;
    logic [2:0]  last_bytes = '0;
    int          words_seen = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Reference model: bit stream -> bytes (+ stuffing) -> 4-byte words
    function automatic void m_words();
        while (ebytes.size() >= 4) begin
            exp_data.push_back({ebytes[0], ebytes[1], ebytes[2], ebytes[3]});
            exp_bytes.push_back(3'd4);
            repeat (4) void'(ebytes.pop_front());
        end
    endfunction

    function automatic void m_bit(input bit b, input bit r);
        logic [7:0] v;
        if (pend.size() == 0) pend_raw = r;
        pend.push_back(b);
        if (pend.size() == 8) begin
            for (int i = 0; i < 8; i++) v[7-i] = pend[i];
            pend.delete();
            ebytes.push_back(v);
            if (STUFF && v == 8'hFF && !pend_raw) ebytes.push_back(8'h00);
            m_words();
        end
    endfunction

    function automatic void m_code(input logic [31:0] c, input int w_in, input bit r);
        int w;
        w = (w_in > 32) ? 32 : w_in;
        if (w == 0) return;
        if (r) while (pend.size() != 0) m_bit(1'b1, 1'b0);
        for (int i = w - 1; i >= 0; i--) m_bit(c[i], r);
    endfunction

    function automatic void m_flush();
        logic [31:0] d;
        while (pend.size() != 0) m_bit(1'b1, 1'b0);
        if (ebytes.size() > 0) begin
            d = '0;
            for (int i = 0; i < ebytes.size(); i++) d[31-8*i -: 8] = ebytes[i];
            exp_data.push_back(d);
            exp_bytes.push_back(3'(ebytes.size()));
            ebytes.delete();
        end
    endfunction

    function automatic void m_reset();
        pend.delete();
        ebytes.delete();
        exp_data.delete();
        exp_bytes.delete();
    endfunction

    // Monitor: compares every transferred word and checks hold-while-stalled
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic [2:0]  prev_bytes = '0;
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", {63'd0, DataOutEnable}, 64'd1);
                chk("hold_data", {32'd0, DataOut}, {32'd0, prev_data});
                chk("hold_bytes", {61'd0, DataOutBytes}, {61'd0, prev_bytes});
            end
            prev_stall = DataOutEnable && !DataOutReady;
            prev_data  = DataOut;
            prev_bytes = DataOutBytes;
            if (DataOutEnable && DataOutReady) begin
                if (exp_data.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%h required=none", DataOut);
                end else begin
                    chk("word_data", {32'd0, DataOut}, {32'd0, exp_data.pop_front()});
                    chk("word_bytes", {61'd0, DataOutBytes}, {61'd0, exp_bytes.pop_front()});
                end
                last_data  = DataOut;
                last_bytes = DataOutBytes;
                words_seen++;
            end
        end
    end

    task automatic send(input logic [31:0] c, input int w, input bit r);
        int n = 0;
        CodeIn     = c;
        CodeWidth  = 6'(w);
        CodeRaw    = r;
        CodeEnable = 1'b1;
        @(negedge clk);
        while (!CodeReady && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!CodeReady) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=notready required=ready");
        end else begin
            m_code(c, w, r);
        end
        @(posedge clk);
        #1;
        CodeEnable = 1'b0;
    endtask

    task automatic do_flush(input int exp_lat, input string tag);
        int n = 0;
        bit seen = 1'b0;
        Flush = 1'b1;
        m_flush();
        @(negedge clk);
        if (FlushDone) seen = 1'b1;
        @(posedge clk);
        #1;
        Flush = 1'b0;
        while (!seen && n < 400) begin
            n++;
            @(negedge clk);
            if (FlushDone) seen = 1'b1;
        end
        chk({tag, "_flushdone_seen"}, {63'd0, seen}, 64'd1);
        if (exp_lat >= 0) chk({tag, "_flush_latency"}, 64'(n), 64'(exp_lat));
        chk({tag, "_drained"}, 64'(exp_data.size()), 64'd0);
        @(negedge clk);
        chk({tag, "_flushdone_pulse"}, {63'd0, FlushDone}, 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout actual=running required=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int n;
        int ws;
        bit saw_low;
        bit rnd_done;
        logic [31:0] c;
        int w;
        bit r;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_codeready", {63'd0, CodeReady}, 64'd1);
        chk("rst_idle", {63'd0, Idle}, 64'd1);
        chk("rst_enable", {63'd0, DataOutEnable}, 64'd0);
        chk("rst_data", {32'd0, DataOut}, 64'd0);
        chk("rst_bytes", {61'd0, DataOutBytes}, 64'd0);
        chk("rst_flushdone", {63'd0, FlushDone}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Full 32-bit code forms one word; check latency bound
        send(32'h12345678, 32, 1'b0);
        n = 1;
        @(negedge clk);
        while (!DataOutEnable && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("latency_le6", {63'd0, (n <= 6)}, 64'd1);
        @(posedge clk);
        #1;
        chk("w32_data", {32'd0, last_data}, 64'h12345678);
        chk("w32_bytes", {61'd0, last_bytes}, 64'd4);
        do_flush(2, "after_w32");

        // Empty flush: no word, FlushDone two cycles later
        ws = words_seen;
        do_flush(2, "empty");
        chk("empty_no_word", 64'(words_seen), 64'(ws));

        // 0xFF stuffing case
        send(32'hFF, 8, 1'b0);
        send(32'h12, 8, 1'b0);
        send(32'h34, 8, 1'b0);
        do_flush(-1, "stuff");
        chk("stuff_data", {32'd0, last_data}, STUFF ? 64'hFF001234 : 64'hFF123400);
        chk("stuff_bytes", {61'd0, last_bytes}, STUFF ? 64'd4 : 64'd3);

        // Short code padded with ones
        send(32'h5, 3, 1'b0);
        do_flush(-1, "pad");
        chk("pad_data", {32'd0, last_data}, 64'hBF000000);
        chk("pad_bytes", {61'd0, last_bytes}, 64'd1);

        // Raw marker after a 1-bit code: aligned, never stuffed
        send(32'h0, 1, 1'b0);
        send(32'hFFD9, 16, 1'b1);
        do_flush(-1, "raw");
        chk("raw_data", {32'd0, last_data}, 64'h7FFFD900);
        chk("raw_bytes", {61'd0, last_bytes}, 64'd3);

        // Zero-width codes (plain and raw) leave the stream unchanged
        send(32'h0, 1, 1'b0);
        send(32'hABC, 0, 1'b0);
        send(32'hFF, 0, 1'b1);
        send(32'h2A, 7, 1'b0);
        do_flush(-1, "w0");
        chk("w0_data", {32'd0, last_data}, 64'h2A000000);
        chk("w0_bytes", {61'd0, last_bytes}, 64'd1);

        // Backpressure: 20 cycles of DataOutReady=0 under 16-bit codes
        saw_low = 1'b0;
        fork
            begin
                DataOutReady = 1'b0;
                repeat (20) @(posedge clk);
                #1;
                DataOutReady = 1'b1;
            end
            begin
                for (int k = 0; k < 14; k++) send($urandom, 16, 1'b0);
            end
            begin
                repeat (20) begin
                    @(negedge clk);
                    if (!CodeReady) saw_low = 1'b1;
                end
            end
        join
        chk("bp_codeready_fell", {63'd0, saw_low}, 64'd1);
        do_flush(-1, "bp");

        // Randomized codes with random downstream readiness
        for (int round = 0; round < 3; round++) begin
            rnd_done = 1'b0;
            fork
                begin
                    for (int k = 0; k < 250; k++) begin
                        c = $urandom;
                        r = ($urandom_range(0, 9) == 0);
                        if (r) w = ($urandom_range(0, 1) == 1) ? 16 : 8;
                        else if ($urandom_range(0, 7) == 0) c = 32'hFFFFFFFF;
                        if (!r) w = $urandom_range(0, 40);
                        send(c, w, r);
                    end
                    rnd_done = 1'b1;
                end
                begin
                    while (!rnd_done) begin
                        @(posedge clk);
                        #1;
                        DataOutReady = ($urandom_range(0, 3) != 0);
                    end
                end
            join
            DataOutReady = 1'b1;
            do_flush(-1, "rand");
        end

        // Reset with 20 bits buffered
        send(32'h3FF, 10, 1'b0);
        send(32'h2AB, 10, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        ws = words_seen;
        rst = 1'b0;
        m_reset();
        @(negedge clk);
        chk("mid_rst_enable", {63'd0, DataOutEnable}, 64'd0);
        chk("mid_rst_data", {32'd0, DataOut}, 64'd0);
        chk("mid_rst_bytes", {61'd0, DataOutBytes}, 64'd0);
        chk("mid_rst_idle", {63'd0, Idle}, 64'd1);
        chk("mid_rst_codeready", {63'd0, CodeReady}, 64'd1);
        chk("mid_rst_flushdone", {63'd0, FlushDone}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("mid_rst_no_word", 64'(words_seen), 64'(ws));
        chk("mid_rst_idle_after", {63'd0, Idle}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aq_jpeg_bitpack.md
AQ_JPEG_BITPACK -- requirements
Module: aq_jpeg_bitpack

Interface
REQ-001 SHALL have parameter CODE_W_MAX, default 32, giving the maximum Huffman/VLI code width in bits (legal range 16..32).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port CodeIn, input, 32, code bits, right-aligned; only the low CodeWidth bits are used.
REQ-005 SHALL have port CodeWidth, input, 6, number of valid bits, 0..32; values above 32 are treated as 32.
REQ-006 SHALL have port CodeRaw, input, 1, which marks the code as a marker or header field: byte-aligned first, never stuffed.
REQ-007 SHALL have port CodeEnable, input, 1, code valid.
REQ-008 SHALL have port CodeReady, output, 1; a code is accepted on a cycle where CodeEnable and CodeReady are both 1.
REQ-009 SHALL have port Flush, input, 1, a one-cycle pulse requesting end-of-stream.
REQ-010 SHALL have port FlushDone, output, 1, a one-cycle pulse when the flush is complete.
REQ-011 SHALL have port DataOut, output, 32, packed stream word, big-endian (first byte in bits [31:24]).
REQ-012 SHALL have port DataOutBytes, output, 3, number of valid bytes 1..4; unused low bytes are 0x00.
REQ-013 SHALL have port DataOutEnable, output, 1, word valid.
REQ-014 SHALL have port DataOutReady, input, 1, downstream FIFO ready; a transfer occurs when DataOutEnable and DataOutReady are both 1.
REQ-015 SHALL have port Idle, output, 1, which is 1 when no bits are buffered and no flush is pending.

Function
REQ-016 SHALL append accepted code bits MSB-first to a bit accumulator of at least 64 bits, with a 7-bit fill count.
REQ-017 SHALL drive CodeReady=1 only when fill count <= 32, state is RUN, and no flush is pending.
REQ-018 SHALL accept CodeWidth=0 with no effect on the stream.
REQ-019 SHALL move at most one byte per cycle from the accumulator to the word assembler whenever fill >= 8.
REQ-020 SHALL emit 0x00 in the next byte slot after every 0xFF byte produced from non-raw bits; the 0x00 costs one extra cycle.
REQ-021 SHALL pad with 1-bits to the next byte boundary before a raw code is appended when fill mod 8 != 0, and SHALL never stuff bytes originating from raw codes.
REQ-022 SHALL present a word when 4 bytes are assembled; DataOut, DataOutBytes and DataOutEnable SHALL hold stable until the transfer.
REQ-023 SHALL provide a one-word skid so assembly continues while one word awaits DataOutReady; when both are full, byte movement stalls and CodeReady falls.
REQ-024 SHALL assert DataOutEnable within 6 cycles after accepting the code that completes a word, provided DataOutReady=1 and no stuffing occurs.
REQ-025 SHALL run the FSM RUN -> PAD (on Flush) -> DRAIN -> DONE -> RUN: PAD adds 1-bits to the byte boundary; DRAIN emits all remaining bytes plus a partial word (DataOutBytes<4) if any; DONE pulses FlushDone for one cycle.
REQ-026 SHALL, on a Flush coinciding with an accepted code, include that code before padding.
REQ-027 SHALL, on a Flush with an empty buffer, emit no word and pulse FlushDone 2 cycles later.
REQ-028 SHALL ignore Flush while already in PAD, DRAIN or DONE.

Reset
REQ-029 SHALL, on rst=0, clear the accumulator, fill count, assembler and skid, set the state to RUN, and drive CodeReady=1, FlushDone=0, DataOut=0, DataOutBytes=0, DataOutEnable=0 and Idle=1.
REQ-030 SHALL discard all pending bits and words on a reset asserted mid-operation, with no partial word emitted.

Configuration
REQ-031 SHALL, when macro AQ_JPEG_BITPACK_STUFF_EN is defined, perform 0xFF/0x00 stuffing per REQ-020; when it is undefined, emit no stuffing bytes, so that non-raw and raw bits are packed identically (raw alignment per REQ-021 still applies).

Structure
REQ-032 SHALL take the FSM state encoding, the 0xFF/0x00 constants and the accumulator width from shared package aq_jpeg_pkg.
REQ-033 SHALL implement word assembly and the skid buffer in sub-module aq_jpeg_bitpack_word.

Verification
REQ-034 SHALL cover: CodeIn=0x12345678, width 32 -> one word DataOut=0x12345678, DataOutBytes=4.
REQ-035 SHALL cover, with stuffing enabled: codes 0xFF, 0x12, 0x34 (width 8 each), then Flush -> DataOut=0xFF001234, bytes=4, then FlushDone; with the macro off -> DataOut=0xFF123400, bytes=3.
REQ-036 SHALL cover: code 0b101 width 3, then Flush -> DataOut=0xBF000000, bytes=1, FlushDone one cycle later or more.
REQ-037 SHALL cover: code 0b0 width 1, then raw 0xFFD9 width 16, then Flush -> DataOut=0x7FFFD900, bytes=3, with no 0x00 inserted after the marker's 0xFF.
REQ-038 SHALL cover: DataOutReady=0 for 20 cycles under continuous 16-bit codes -> CodeReady falls, DataOut stays stable, and no bits are lost after release (scoreboard match).
REQ-039 SHALL cover: rst pulsed with 20 bits buffered -> all outputs at reset values, Idle=1, and no word emitted afterwards.
